// File: rtl/debug_tx_fifo_serializer_if.sv
// debug_tx_fifo_serializer_if: word-write / byte-stream handshake and status bundle for the debug TX buffer
interface debug_tx_fifo_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 75
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_clr_overflow;
  logic                  i_tx_ready;
  logic [7:0]            o_tx_byte;
  logic                  o_tx_valid;
  logic                  o_full;
  logic                  o_almost_full;
  logic                  o_overflow;
  logic [CW-1:0]         o_count;
  logic                  o_empty;
  logic                  o_busy;
  modport slave (
    input  i_wr_en, i_wr_data, i_clr_overflow, i_tx_ready,
    output o_tx_byte, o_tx_valid, o_full, o_almost_full, o_overflow, o_count, o_empty, o_busy
  );
  modport master (
    output i_wr_en, i_wr_data, i_clr_overflow, i_tx_ready,
    input  o_tx_byte, o_tx_valid, o_full, o_almost_full, o_overflow, o_count, o_empty, o_busy
  );
endinterface

// File: rtl/debug_tx_fifo_serializer.sv
// debug_tx_fifo_serializer: circular word FIFO feeding a byte serialiser with valid/ready output
module debug_tx_fifo_serializer #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 75,
  parameter int AF_THRESHOLD = FIFO_DEPTH - 4,
  parameter bit LSB_FIRST    = 1'b1
) (
  input logic i_clk,
  input logic i_reset,
  debug_tx_fifo_serializer_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  r_overflow;
  logic                  w_full, w_accept, w_hs, w_last, w_pop;
  assign w_full   = r_count == CW'(FIFO_DEPTH);
  assign w_accept = bus.i_wr_en && !w_full;
  assign w_hs     = r_state == SEND && bus.i_tx_ready;
  assign w_last   = r_idx == IW'(BYTES - 1);
  // Popping on the last handshake chains words back-to-back without an idle cycle
  always_comb begin
    w_pop  = (r_state == IDLE || (w_hs && w_last)) && r_count != '0;
    w_next = w_pop ? SEND : (r_state == SEND && !(w_hs && w_last)) ? SEND : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr == AW'(FIFO_DEPTH - 1) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr == AW'(FIFO_DEPTH - 1) ? '0 : r_rd_ptr + AW'(1);
      r_count    <= r_count + CW'(w_accept) - CW'(w_pop);
      r_overflow <= (bus.i_wr_en && w_full) || (r_overflow && !bus.i_clr_overflow);
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
        r_idx   <= '0;
      end else if (w_hs && !w_last) begin
        r_shift <= LSB_FIRST ? r_shift >> 8 : r_shift << 8;
        r_idx   <= r_idx + IW'(1);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_accept && !i_reset) r_mem[r_wr_ptr] <= bus.i_wr_data;
  end
  assign bus.o_tx_valid    = r_state == SEND;
  assign bus.o_tx_byte     = r_state == SEND ? (LSB_FIRST ? r_shift[7:0] : r_shift[DATA_WIDTH-1 -: 8]) : 8'h00;
  assign bus.o_full        = w_full;
  assign bus.o_almost_full = r_count >= CW'(AF_THRESHOLD);
  assign bus.o_overflow    = r_overflow;
  assign bus.o_count       = r_count;
  assign bus.o_empty       = r_count == '0 && r_state == IDLE;
  assign bus.o_busy        = r_state == SEND;
endmodule

// File: tb/tb_debug_tx_fifo_serializer.sv
// tb_debug_tx_fifo_serializer: directed and randomized checks of the debug TX FIFO serializer against a byte-queue model
module tb_debug_tx_fifo_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  debug_tx_fifo_serializer_if #(.DATA_WIDTH(32), .FIFO_DEPTH(75)) bl ();
  debug_tx_fifo_serializer_if #(.DATA_WIDTH(32), .FIFO_DEPTH(75)) bm ();
  debug_tx_fifo_serializer #(.DATA_WIDTH(32), .FIFO_DEPTH(75), .AF_THRESHOLD(71), .LSB_FIRST(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bl.slave)
  );
  debug_tx_fifo_serializer #(.DATA_WIDTH(32), .FIFO_DEPTH(75), .AF_THRESHOLD(71), .LSB_FIRST(1'b0)) dut_m (
    .i_clk(clk), .i_reset(rst), .bus(bm.slave)
  );
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: every accepted word becomes its four bytes, low byte first
  task automatic push(input logic [31:0] w);
    for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
  endtask
  task automatic drain();
    bl.i_tx_ready = 1'b1;
    for (int i = 0; i < 3000 && bl.o_empty !== 1'b1; i++) tick();
    check("drain_empty", {31'h0, bl.o_empty}, 32'h1);
    check("drain_queue", 32'(q.size()), 32'h0);
  endtask
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", {31'h0, bl.o_tx_valid}, 32'h1);
        check("stall_byte", {24'h0, bl.o_tx_byte}, {24'h0, prev_byte});
      end
      if (bl.o_tx_valid && bl.i_tx_ready) begin
        if (q.size() == 0) check("stream_extra_byte", {24'h0, bl.o_tx_byte}, 32'h100);
        else check("stream_byte", {24'h0, bl.o_tx_byte}, {24'h0, q.pop_front()});
      end
      prev_stall <= bl.o_tx_valid && !bl.i_tx_ready;
      prev_byte  <= bl.o_tx_byte;
    end
  end
  initial begin
    logic [7:0]  exp_l [4];
    logic [7:0]  exp_m [4];
    logic [31:0] w;
    int n, held, cnt;
    exp_l = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_m = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bl.i_wr_en = 1'b0; bl.i_wr_data = '0; bl.i_clr_overflow = 1'b0; bl.i_tx_ready = 1'b0;
    bm.i_wr_en = 1'b0; bm.i_wr_data = '0; bm.i_clr_overflow = 1'b0; bm.i_tx_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'h0, bl.o_tx_valid}, 32'h0);
    check("rst_byte", {24'h0, bl.o_tx_byte}, 32'h0);
    check("rst_full", {31'h0, bl.o_full}, 32'h0);
    check("rst_afull", {31'h0, bl.o_almost_full}, 32'h0);
    check("rst_ovf", {31'h0, bl.o_overflow}, 32'h0);
    check("rst_count", 32'(bl.o_count), 32'h0);
    check("rst_empty", {31'h0, bl.o_empty}, 32'h1);
    check("rst_busy", {31'h0, bl.o_busy}, 32'h0);
    rst = 1'b0;
    // 1: single word, LSB first, one cycle write-to-valid latency
    bl.i_tx_ready = 1'b1; bl.i_wr_en = 1'b1; bl.i_wr_data = 32'hDEADBEEF; push(32'hDEADBEEF);
    tick();
    bl.i_wr_en = 1'b0;
    check("t1_valid_early", {31'h0, bl.o_tx_valid}, 32'h0);
    check("t1_count_one", 32'(bl.o_count), 32'h1);
    tick();
    for (int b = 0; b < 4; b++) begin
      check("t1_byte", {24'h0, bl.o_tx_byte}, {24'h0, exp_l[b]});
      check("t1_busy", {31'h0, bl.o_busy}, 32'h1);
      tick();
    end
    check("t1_valid_end", {31'h0, bl.o_tx_valid}, 32'h0);
    check("t1_empty_end", {31'h0, bl.o_empty}, 32'h1);
    check("t1_count_end", 32'(bl.o_count), 32'h0);
    // 2: MSB-first instance
    bm.i_tx_ready = 1'b1; bm.i_wr_en = 1'b1; bm.i_wr_data = 32'hDEADBEEF;
    tick();
    bm.i_wr_en = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      check("t2_valid", {31'h0, bm.o_tx_valid}, 32'h1);
      check("t2_byte", {24'h0, bm.o_tx_byte}, {24'h0, exp_m[b]});
      tick();
    end
    check("t2_valid_end", {31'h0, bm.o_tx_valid}, 32'h0);
    check("t2_empty_end", {31'h0, bm.o_empty}, 32'h1);
    // 3: three back-to-back words stream 12 bytes with no bubble
    for (int c = 0; c < 14; c++) begin
      bl.i_wr_en = c < 3;
      if (c < 3) begin
        w = $urandom;
        bl.i_wr_data = w;
        push(w);
      end
      tick();
      if (c >= 1 && c <= 12) begin
        check("t3_valid", {31'h0, bl.o_tx_valid}, 32'h1);
        check("t3_busy", {31'h0, bl.o_busy}, 32'h1);
      end
      if (c == 13) check("t3_valid_end", {31'h0, bl.o_tx_valid}, 32'h0);
    end
    // 4: fill with output stalled; 76 words fit, the 77th overflows
    bl.i_tx_ready = 1'b0;
    for (int j = 0; j < 77; j++) begin
      w = $urandom;
      bl.i_wr_en = 1'b1; bl.i_wr_data = w;
      if (j < 76) push(w);
      tick();
      held = j + 1 < 76 ? j + 1 : 76;
      cnt = held - (j >= 1 ? 1 : 0);
      check("t4_count", 32'(bl.o_count), 32'(cnt));
      check("t4_afull", {31'h0, bl.o_almost_full}, {31'h0, cnt >= 71});
      check("t4_full", {31'h0, bl.o_full}, {31'h0, cnt == 75});
      check("t4_ovf", {31'h0, bl.o_overflow}, {31'h0, j == 76});
    end
    bl.i_clr_overflow = 1'b1;
    tick();
    check("t4_set_wins", {31'h0, bl.o_overflow}, 32'h1);
    check("t4_count_hold", 32'(bl.o_count), 32'd75);
    bl.i_wr_en = 1'b0;
    tick();
    bl.i_clr_overflow = 1'b0;
    check("t4_ovf_clr", {31'h0, bl.o_overflow}, 32'h0);
    drain();
    // 5: 200 sequential words with random back-pressure, crossing pointer wrap
    n = 0;
    for (int c = 0; c < 20000 && n < 200; c++) begin
      bl.i_tx_ready = $urandom_range(3) != 0;
      bl.i_wr_en = $urandom_range(7) == 0;
      if (bl.i_wr_en) begin
        bl.i_wr_data = 32'hC0DE0000 + 32'(n);
        push(bl.i_wr_data);
        n++;
      end
      tick();
    end
    bl.i_wr_en = 1'b0;
    drain();
    check("t5_no_ovf", {31'h0, bl.o_overflow}, 32'h0);
    // 6: reset while sending byte index 2 discards everything
    bl.i_tx_ready = 1'b0; bl.i_wr_en = 1'b1; bl.i_wr_data = 32'hA1B2C3D4; push(32'hA1B2C3D4);
    tick();
    bl.i_wr_en = 1'b0;
    tick();
    bl.i_tx_ready = 1'b1;
    tick();
    tick();
    bl.i_tx_ready = 1'b0;
    check("t6_idx2_byte", {24'h0, bl.o_tx_byte}, 32'hB2);
    rst = 1'b1;
    q.delete();
    tick();
    check("t6_rst_valid", {31'h0, bl.o_tx_valid}, 32'h0);
    check("t6_rst_count", 32'(bl.o_count), 32'h0);
    check("t6_rst_empty", {31'h0, bl.o_empty}, 32'h1);
    rst = 1'b0;
    bl.i_tx_ready = 1'b1; bl.i_wr_en = 1'b1; bl.i_wr_data = 32'h11223344; push(32'h11223344);
    tick();
    bl.i_wr_en = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_quiet", {31'h0, bl.o_tx_valid}, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
